// File: rtl/prf_wr_arbiter_if.sv
// Writeback request bus and banked PRF write bus for the PRF write arbiter.
// The master is the writeback side; the slave is the arbiter.
interface prf_wr_arbiter_if #(
    parameter int PRF_WR_COUNT   = 8,
    parameter int PRF_BANK_COUNT = 4,
    parameter int LOG_PR_COUNT   = 7,
    parameter int XLEN           = 32
);
    logic [PRF_WR_COUNT-1:0]                    wr_req_valid_by_wr;
    logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]  wr_req_PR_by_wr;
    logic [PRF_WR_COUNT-1:0][XLEN-1:0]          wr_req_data_by_wr;
    logic [PRF_WR_COUNT-1:0]                    wr_req_ready_by_wr;

    logic [PRF_BANK_COUNT-1:0]                   prf_wr_valid_by_bank;
    logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] prf_wr_PR_by_bank;
    logic [PRF_BANK_COUNT-1:0][XLEN-1:0]         prf_wr_data_by_bank;

    modport master (
        output wr_req_valid_by_wr,
        output wr_req_PR_by_wr,
        output wr_req_data_by_wr,
        input  wr_req_ready_by_wr,
        input  prf_wr_valid_by_bank,
        input  prf_wr_PR_by_bank,
        input  prf_wr_data_by_bank
    );

    modport slave (
        input  wr_req_valid_by_wr,
        input  wr_req_PR_by_wr,
        input  wr_req_data_by_wr,
        output wr_req_ready_by_wr,
        output prf_wr_valid_by_bank,
        output prf_wr_PR_by_bank,
        output prf_wr_data_by_bank
    );
endinterface

// File: rtl/prf_wr_arbiter.sv
// Per-bank round-robin arbitration of writeback requesters onto the banked PRF write ports.
// Grants are combinational; the selected write is registered and presented for one cycle.
module prf_wr_arbiter #(
    parameter int PRF_WR_COUNT       = 8,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_PR_COUNT       = 7,
    parameter int XLEN               = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    prf_wr_arbiter_if.slave bus
);
    localparam int LOG_WR = $clog2(PRF_WR_COUNT);
    typedef logic [LOG_WR-1:0] wr_idx_t;

    wr_idx_t [PRF_BANK_COUNT-1:0]                rr_ptr_q;
    wr_idx_t [PRF_BANK_COUNT-1:0]                rr_ptr_d;
    logic    [PRF_BANK_COUNT-1:0]                prf_wr_valid_q;
    logic    [PRF_BANK_COUNT-1:0]                prf_wr_valid_d;
    logic    [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] prf_wr_pr_q;
    logic    [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0] prf_wr_pr_d;
    logic    [PRF_BANK_COUNT-1:0][XLEN-1:0]      prf_wr_data_q;
    logic    [PRF_BANK_COUNT-1:0][XLEN-1:0]      prf_wr_data_d;

    logic    [PRF_BANK_COUNT-1:0]                bank_found;
    wr_idx_t [PRF_BANK_COUNT-1:0]                bank_winner;
    logic    [PRF_WR_COUNT-1:0]                  grant;

    // Each bank scans circularly from its own pointer; the index sum wraps naturally.
    always_comb begin : arbitrate
        wr_idx_t idx;
        idx         = '0;
        bank_found  = '0;
        bank_winner = '0;
        grant       = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            for (int k = 0; k < PRF_WR_COUNT; k++) begin
                idx = rr_ptr_q[b] + wr_idx_t'(k);
                if (!bank_found[b] && bus.wr_req_valid_by_wr[idx] &&
                    (bus.wr_req_PR_by_wr[idx][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b))) begin
                    bank_found[b]  = 1'b1;
                    bank_winner[b] = idx;
                end
            end
            if (bank_found[b]) begin
                grant[bank_winner[b]] = 1'b1;
            end
        end
    end

    always_comb begin : next_state
        prf_wr_valid_d = '0;
        prf_wr_pr_d    = prf_wr_pr_q;
        prf_wr_data_d  = prf_wr_data_q;
        rr_ptr_d       = rr_ptr_q;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            if (bank_found[b]) begin
                prf_wr_valid_d[b] = 1'b1;
                prf_wr_pr_d[b]    = bus.wr_req_PR_by_wr[bank_winner[b]];
                prf_wr_data_d[b]  = bus.wr_req_data_by_wr[bank_winner[b]];
                rr_ptr_d[b]       = bank_winner[b] + wr_idx_t'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_ptr_q       <= '0;
            prf_wr_valid_q <= '0;
            prf_wr_pr_q    <= '0;
            prf_wr_data_q  <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            prf_wr_valid_q <= prf_wr_valid_d;
            prf_wr_pr_q    <= prf_wr_pr_d;
            prf_wr_data_q  <= prf_wr_data_d;
        end
    end

    // Gating with nRST keeps grants low while reset is held even though ready is combinational.
    assign bus.wr_req_ready_by_wr   = grant & {PRF_WR_COUNT{nRST}};
    assign bus.prf_wr_valid_by_bank = prf_wr_valid_q;
    assign bus.prf_wr_PR_by_bank    = prf_wr_pr_q;
    assign bus.prf_wr_data_by_bank  = prf_wr_data_q;
endmodule
